// File: rtl/fetch_pc.sv
// rtl/fetch_pc.sv - instruction fetch PC unit with IF/ID register and RUN/HALT fault FSM
// Optional fetch counter output CNT_IF is built only when FETCH_CNT_EN is defined.
module fetch_pc #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 1000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        STALL,
    input  logic        BR_TAKEN,
    input  logic [31:0] BR_TARGET,
    output logic [31:0] DR,
    input  logic [31:0] INS_IN,
    output logic [31:0] PC_ID,
    output logic [31:0] PC4_ID,
    output logic [31:0] INS_ID,
    output logic        VALID_ID,
    output logic        FAULT
`ifdef FETCH_CNT_EN
    ,
    output logic [31:0] CNT_IF
`endif
);

    localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_pc_id;
    logic [31:0] r_pc4_id;
    logic [31:0] r_ins_id;
    logic        r_valid_id;

    logic [31:0] w_pc_nxt;
    logic [31:0] w_pc_id_nxt;
    logic [31:0] w_pc4_id_nxt;
    logic [31:0] w_ins_id_nxt;
    logic        w_valid_id_nxt;
    logic        w_fetch;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_pc;
    logic        w_unused_bits;

    assign w_pc_plus4    = r_pc + 32'd4;
    assign w_br_pc       = {BR_TARGET[31:2], 2'b00};
    // Low target bits are discarded by word alignment.
    assign w_unused_bits = &{1'b0, BR_TARGET[1:0]};

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_pc_id_nxt    = r_pc_id;
        w_pc4_id_nxt   = r_pc4_id;
        w_ins_id_nxt   = r_ins_id;
        w_valid_id_nxt = r_valid_id;
        w_fetch        = 1'b0;
        case (r_state)
            S_RUN: begin
                if (BR_TAKEN) begin
                    // Redirect wins over stall and squashes the word being fetched.
                    w_pc_nxt       = w_br_pc;
                    w_ins_id_nxt   = 32'd0;
                    w_valid_id_nxt = 1'b0;
                end else if (!STALL) begin
                    if (r_pc <= LAST_ADDR) begin
                        w_pc_nxt       = w_pc_plus4;
                        w_pc_id_nxt    = r_pc;
                        w_pc4_id_nxt   = w_pc_plus4;
                        w_ins_id_nxt   = INS_IN;
                        w_valid_id_nxt = 1'b1;
                        w_fetch        = 1'b1;
                    end else begin
                        w_state_nxt    = S_HALT;
                        w_ins_id_nxt   = 32'd0;
                        w_valid_id_nxt = 1'b0;
                    end
                end
            end
            S_HALT: begin
                w_valid_id_nxt = 1'b0;
                if (BR_TAKEN) begin
                    w_state_nxt  = S_RUN;
                    w_pc_nxt     = w_br_pc;
                    w_ins_id_nxt = 32'd0;
                end
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_RUN;
            r_pc       <= RESET_PC;
            r_pc_id    <= 32'd0;
            r_pc4_id   <= 32'd0;
            r_ins_id   <= 32'd0;
            r_valid_id <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_pc_id    <= w_pc_id_nxt;
            r_pc4_id   <= w_pc4_id_nxt;
            r_ins_id   <= w_ins_id_nxt;
            r_valid_id <= w_valid_id_nxt;
        end
    end

`ifdef FETCH_CNT_EN
    logic [31:0] r_cnt_if;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt_if <= 32'd0;
        end else if (w_fetch) begin
            r_cnt_if <= r_cnt_if + 32'd1;
        end
    end

    assign CNT_IF = r_cnt_if;
`else
    logic w_unused_fetch;
    assign w_unused_fetch = w_fetch;
`endif

    assign DR       = r_pc;
    assign PC_ID    = r_pc_id;
    assign PC4_ID   = r_pc4_id;
    assign INS_ID   = r_ins_id;
    assign VALID_ID = r_valid_id;
    assign FAULT    = (r_state == S_HALT);

endmodule

// File: tb/tb_fetch_pc.sv
// tb/tb_fetch_pc.sv - scoreboard bench for fetch_pc (define FETCH_CNT_EN to also check CNT_IF)
module tb_fetch_pc;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        STALL = 1'b0;
    logic        BR_TAKEN = 1'b0;
    logic [31:0] BR_TARGET = 32'd0;
    logic [31:0] DR;
    logic [31:0] INS_IN;
    logic [31:0] PC_ID;
    logic [31:0] PC4_ID;
    logic [31:0] INS_ID;
    logic        VALID_ID;
    logic        FAULT;
`ifdef FETCH_CNT_EN
    logic [31:0] CNT_IF;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] dr;
        logic [31:0] pc_id;
        logic [31:0] pc4_id;
        logic [31:0] ins_id;
        logic [31:0] cnt;
        logic        valid;
        logic        fault;
    } exp_t;

    exp_t sbq[$];

    // Reference state for the unit, derived from the requirements.
    logic [31:0] m_pc, m_pc_id, m_pc4, m_ins, m_cnt;
    logic        m_valid, m_halt;

    fetch_pc #(.RESET_PC(32'h0000_0000), .MEM_BYTES(1000)) dut (
        .CLK(CLK), .RST(RST), .STALL(STALL), .BR_TAKEN(BR_TAKEN),
        .BR_TARGET(BR_TARGET), .DR(DR), .INS_IN(INS_IN), .PC_ID(PC_ID),
        .PC4_ID(PC4_ID), .INS_ID(INS_ID), .VALID_ID(VALID_ID), .FAULT(FAULT)
`ifdef FETCH_CNT_EN
        , .CNT_IF(CNT_IF)
`endif
    );

    always #5 CLK = ~CLK;

    // Byte i of memory holds (i+1) mod 256; words are big-endian.
    function automatic logic [31:0] ins_word(input logic [31:0] a);
        logic [7:0] b0, b1, b2, b3;
        if (a > 32'd996) return 32'd0;
        b0 = 8'((a + 32'd1) & 32'hFF);
        b1 = 8'((a + 32'd2) & 32'hFF);
        b2 = 8'((a + 32'd3) & 32'hFF);
        b3 = 8'((a + 32'd4) & 32'hFF);
        return {b0, b1, b2, b3};
    endfunction

    assign INS_IN = ins_word(DR);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic stall, input logic br, input logic [31:0] tgt);
        exp_t e;
        exp_t g;
        @(negedge CLK);
        RST = rst; STALL = stall; BR_TAKEN = br; BR_TARGET = tgt;
        if (rst) begin
            m_pc = 32'd0; m_pc_id = 32'd0; m_pc4 = 32'd0; m_ins = 32'd0;
            m_valid = 1'b0; m_halt = 1'b0; m_cnt = 32'd0;
        end else if (!m_halt) begin
            if (br) begin
                m_pc = {tgt[31:2], 2'b00}; m_valid = 1'b0; m_ins = 32'd0;
            end else if (!stall) begin
                if (m_pc <= 32'd996) begin
                    m_pc_id = m_pc; m_pc4 = m_pc + 32'd4; m_ins = ins_word(m_pc);
                    m_valid = 1'b1; m_cnt = m_cnt + 32'd1; m_pc = m_pc + 32'd4;
                end else begin
                    m_halt = 1'b1; m_valid = 1'b0; m_ins = 32'd0;
                end
            end
        end else begin
            m_valid = 1'b0;
            if (br) begin
                m_pc = {tgt[31:2], 2'b00}; m_halt = 1'b0; m_ins = 32'd0;
            end
        end
        e.dr = m_pc; e.pc_id = m_pc_id; e.pc4_id = m_pc4; e.ins_id = m_ins;
        e.cnt = m_cnt; e.valid = m_valid; e.fault = m_halt;
        sbq.push_back(e);
        @(posedge CLK);
        #1;
        g = sbq.pop_front();
        chk("dr", DR, g.dr);
        chk("pc_id", PC_ID, g.pc_id);
        chk("pc4_id", PC4_ID, g.pc4_id);
        chk("ins_id", INS_ID, g.ins_id);
        chk("valid_id", {31'd0, VALID_ID}, {31'd0, g.valid});
        chk("fault", {31'd0, FAULT}, {31'd0, g.fault});
`ifdef FETCH_CNT_EN
        chk("cnt_if", CNT_IF, g.cnt);
`endif
    endtask

    initial begin
        step(1'b1, 1'b0, 1'b0, 32'd0);
        chk("rst_dr", DR, 32'd0);
        chk("rst_valid", {31'd0, VALID_ID}, 32'd0);

        step(1'b0, 1'b0, 1'b0, 32'd0);
        chk("f1_dr", DR, 32'd4);
        chk("f1_ins", INS_ID, 32'h01020304);
        chk("f1_pc4", PC4_ID, 32'd4);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        chk("f2_dr", DR, 32'd8);
        chk("f2_ins", INS_ID, 32'h05060708);
        chk("f2_pcid", PC_ID, 32'd4);

        step(1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        chk("stall_dr", DR, 32'd8);
        chk("stall_ins", INS_ID, 32'h05060708);
`ifdef FETCH_CNT_EN
        chk("stall_cnt", CNT_IF, 32'd2);
`endif
        step(1'b0, 1'b0, 1'b0, 32'd0);
        chk("f3_dr", DR, 32'd12);
        chk("f3_ins", INS_ID, 32'h090A0B0C);

        step(1'b0, 1'b0, 1'b1, 32'd4);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0013);
        chk("br_dr", DR, 32'd16);
        chk("br_valid", {31'd0, VALID_ID}, 32'd0);
        chk("br_ins", INS_ID, 32'd0);

        step(1'b0, 1'b0, 1'b1, 32'd999);
        chk("edge_dr", DR, 32'd996);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        chk("last_valid", {31'd0, VALID_ID}, 32'd1);
        chk("last_pcid", PC_ID, 32'd996);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        chk("halt_fault", {31'd0, FAULT}, 32'd1);
        chk("halt_dr", DR, 32'd1000);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        chk("halt_hold", {31'd0, FAULT}, 32'd1);
        step(1'b0, 1'b0, 1'b1, 32'd0);
        chk("recover_fault", {31'd0, FAULT}, 32'd0);
        chk("recover_dr", DR, 32'd0);

        step(1'b0, 1'b0, 1'b1, 32'd1000);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        chk("oob_fault", {31'd0, FAULT}, 32'd1);
        step(1'b1, 1'b0, 1'b1, 32'd8);
        chk("hrst_dr", DR, 32'd0);
        chk("hrst_fault", {31'd0, FAULT}, 32'd0);
`ifdef FETCH_CNT_EN
        chk("hrst_cnt", CNT_IF, 32'd0);
`endif

        for (int i = 0; i < 60; i++) begin
            logic r, s, b;
            r = ($urandom_range(0, 29) == 0);
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 5) == 0);
            step(r, s, b, 32'($urandom_range(900, 1010)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_pc.md
FETCH_PC -- requirements
Module: fetch_pc

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Parameter MEM_BYTES, default 1000, is the instruction-memory size in bytes; valid fetch addresses are 0..MEM_BYTES-4.
REQ-003 Port CLK  in  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port RST  in  1  is the reset; reset is synchronous and active-high.
REQ-005 Port STALL  in  1  holds the PC and the IF/ID register when high.
REQ-006 Port BR_TAKEN  in  1  requests a redirect to BR_TARGET and flushes the instruction currently being fetched.
REQ-007 Port BR_TARGET  in  32  is the redirect byte address.
REQ-008 Port DR  out  32  is the byte address driven to instruction memory; it equals the PC register.
REQ-009 Port INS_IN  in  32  is the big-endian instruction word returned combinationally by instruction memory for DR.
REQ-010 Ports PC_ID, PC4_ID, INS_ID  out  32 each carry the registered fetch PC, PC+4 and instruction to decode.
REQ-011 Port VALID_ID  out  1  marks INS_ID as a real instruction.
REQ-012 Port FAULT  out  1  is high while the unit is in HALT.

Function
REQ-013 DR SHALL be combinational from the PC register, with zero-cycle latency to memory; the IF/ID outputs SHALL appear one edge after DR.
REQ-014 The state machine SHALL have two states: RUN and HALT.
REQ-015 RUN, BR_TAKEN=1: PC <= {BR_TARGET[31:2],2'b00}, VALID_ID <= 0, INS_ID <= 0, PC_ID and PC4_ID hold; the redirect takes priority over STALL.
REQ-016 RUN, BR_TAKEN=0, STALL=1: PC and all IF/ID outputs SHALL hold their values.
REQ-017 RUN, BR_TAKEN=0, STALL=0, PC<=MEM_BYTES-4: PC <= PC+4 (modulo 2^32), PC_ID <= PC, PC4_ID <= PC+4, INS_ID <= INS_IN, VALID_ID <= 1.
REQ-018 RUN, BR_TAKEN=0, STALL=0, PC>MEM_BYTES-4: the unit SHALL enter HALT, PC holds, VALID_ID <= 0, INS_ID <= 0.
REQ-019 HALT: FAULT=1, PC holds, VALID_ID=0, STALL ignored; BR_TAKEN=1 SHALL load the aligned target and return to RUN with FAULT=0 on the next cycle.
REQ-020 A redirect to an out-of-range target SHALL be accepted and SHALL fault on the following non-stalled cycle per REQ-018.
REQ-021 PC+4 overflow from 32'hFFFF_FFFC SHALL wrap to 0 (reachable only when MEM_BYTES is large).

Reset
REQ-022 RST=1 at an edge SHALL set PC=RESET_PC, PC_ID=0, PC4_ID=0, INS_ID=0, VALID_ID=0, FAULT=0, state=RUN, and overrides BR_TAKEN and STALL.
REQ-023 Reset asserted mid-stall or in HALT SHALL produce the same state as REQ-022; DR=RESET_PC in the cycle after reset.

Configuration
REQ-024 With macro FETCH_CNT_EN defined: output CNT_IF (out, 32) SHALL count edges where VALID_ID is loaded with 1, wrap at 2^32, reset to 0, and hold during stall and HALT.
REQ-025 Without FETCH_CNT_EN: the CNT_IF port and counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-026 Reset, then 3 free cycles with mem bytes 0..11 = 01..0C -> DR 0,4,8,12; INS_ID 32'h01020304 then 32'h05060708, VALID_ID=1, PC4_ID=PC_ID+4.
REQ-027 STALL=1 for 2 cycles at PC=8 -> DR stays 8, INS_ID/PC_ID unchanged, CNT_IF unchanged (when FETCH_CNT_EN).
REQ-028 BR_TAKEN=1 with BR_TARGET=32'h0000_0013 and STALL=1 at PC=4 -> next DR=16, VALID_ID=0, INS_ID=0.
REQ-029 MEM_BYTES=1000, redirect to 996 and run 2 cycles -> fetch at 996 is valid; the next cycle enters HALT with FAULT=1 and DR=1000; BR_TAKEN to 0 -> FAULT=0 and DR=0.
REQ-030 RST=1 asserted while in HALT with BR_TAKEN=1 -> DR=RESET_PC, FAULT=0, VALID_ID=0, CNT_IF=0.
